// File: rtl/btb_assoc_if.sv
// Fetch/execute-side signal bundle for the set-associative branch target buffer.
// The perf_* counters exist only when BTB_PERF_EN is defined.
interface btb_assoc_if;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;
`endif

  modport master (
    output flush, lookup_valid, lookup_pc,
    output update_valid, update_pc, update_target, update_taken,
    input  pred_hit, pred_taken, pred_target
`ifdef BTB_PERF_EN
    , input perf_lookups, perf_hits
`endif
  );

  modport slave (
    input  flush, lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_target, update_taken,
    output pred_hit, pred_taken, pred_target
`ifdef BTB_PERF_EN
    , output perf_lookups, perf_hits
`endif
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational fetch lookup, execute-side training, round-robin
// victim per set. Optional lookup/hit counters are built when BTB_PERF_EN is defined.
module btb_assoc #(
  parameter int ENTRIES = 64,
  parameter int WAYS    = 2,
  parameter int TAG_W   = 10,
  parameter int CTR_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  btb_assoc_if.slave  bus
);

  localparam int SETS     = ENTRIES / WAYS;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [WAY_W-1:0] way_t;
  typedef logic [CTR_W-1:0] ctr_t;

  function automatic idx_t idx_of(input logic [31:0] pc);
    if (IDX_BITS == 0) return '0;
    else               return pc[IDX_W+1:2];
  endfunction

  function automatic tag_t tag_of(input logic [31:0] pc);
    return pc[IDX_BITS+TAG_W+1:IDX_BITS+2];
  endfunction

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  ctr_t            ctr_q   [SETS][WAYS];
  ctr_t            ctr_d   [SETS][WAYS];
  way_t            rr_q    [SETS];
  way_t            rr_d    [SETS];
  tag_t            tag_q   [SETS][WAYS];
  logic [31:0]     tgt_q   [SETS][WAYS];

  // Only the low index/tag fields of the PCs select state; the rest is don't-care.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc, bus.update_pc};

  // ---------------- Lookup (reads pre-edge state only) ----------------
  idx_t lk_idx;
  tag_t lk_tag;
  logic lk_hit;
  way_t lk_way;

  assign lk_idx = idx_of(bus.lookup_pc);
  assign lk_tag = tag_of(bus.lookup_pc);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = way_t'(w);
      end
    end
  end

  assign bus.pred_hit    = bus.lookup_valid && lk_hit;
  assign bus.pred_taken  = bus.pred_hit && ctr_q[lk_idx][lk_way][CTR_W-1];
  assign bus.pred_target = bus.pred_hit ? tgt_q[lk_idx][lk_way] : 32'h0;

  // ---------------- Update: hit detection and victim choice ----------------
  idx_t up_idx;
  tag_t up_tag;
  logic up_hit;
  way_t up_way;
  logic inv_found;
  way_t inv_way;
  way_t alloc_way;
  logic use_rr;

  assign up_idx = idx_of(bus.update_pc);
  assign up_tag = tag_of(bus.update_pc);

  always_comb begin
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = way_t'(w);
      end
      if (!valid_q[up_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = way_t'(w);
      end
    end
    use_rr    = (WAYS > 1) && !inv_found;
    alloc_way = (WAYS == 1) ? '0 : (inv_found ? inv_way : rr_q[up_idx]);
  end

  // ---------------- Next state ----------------
  logic tgt_we;
  logic tag_we;
  way_t wr_way;

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    tgt_we  = 1'b0;
    tag_we  = 1'b0;
    wr_way  = '0;
    if (bus.flush) begin
      // Flush wins over a same-cycle update; counters are left stale behind clear valids.
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        rr_d[s]    = '0;
      end
    end else if (bus.update_valid) begin
      if (up_hit) begin
        wr_way = up_way;
        if (bus.update_taken) begin
          tgt_we = 1'b1;
          if (ctr_q[up_idx][up_way] != '1)
            ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] + 1'b1;
        end else if (ctr_q[up_idx][up_way] != '0) begin
          ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] - 1'b1;
        end
      end else if (bus.update_taken) begin
        wr_way                       = alloc_way;
        tgt_we                       = 1'b1;
        tag_we                       = 1'b1;
        valid_d[up_idx][alloc_way]   = 1'b1;
        ctr_d[up_idx][alloc_way]     = CTR_INIT;
        if (use_rr) rr_d[up_idx]     = rr_q[up_idx] + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      rr_q    <= rr_d;
    end
  end

  // NOTE: tag/target storage is deliberately not reset; valid bits gate every read of it.
  always_ff @(posedge clk) begin
    if (tgt_we) tgt_q[up_idx][wr_way] <= bus.update_target;
    if (tag_we) tag_q[up_idx][wr_way] <= up_tag;
  end

`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups_q;
  logic [31:0] perf_hits_q;

  // Saturating event counters; flush does not touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lookups_q <= '0;
      perf_hits_q    <= '0;
    end else begin
      if (bus.lookup_valid && perf_lookups_q != '1) perf_lookups_q <= perf_lookups_q + 1'b1;
      if (bus.pred_hit && perf_hits_q != '1)        perf_hits_q    <= perf_hits_q + 1'b1;
    end
  end

  assign bus.perf_lookups = perf_lookups_q;
  assign bus.perf_hits    = perf_hits_q;
`endif

endmodule
